// File: rtl/tape_cache_bram.sv
// Tape image cache: byte RAM written by the download path and read back
// by the tape parser through a registered, chip-selected port. The read
// port is read-first, so a collision with a write returns the old byte.
module tape_cache_bram #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int INIT_ADDR_WIDTH = 25
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bram_download,
    input  logic                       bram_wr,
    input  logic [INIT_ADDR_WIDTH-1:0] bram_init_address,
    input  logic [DATA_WIDTH-1:0]      bram_din,
    input  logic [ADDR_WIDTH-1:0]      addr,
    output logic [DATA_WIDTH-1:0]      dout,
    input  logic                       cs
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage has no reset and no initial contents so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [DATA_WIDTH-1:0] dout_reg;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  upper_zero;
    logic                  wr_en;

    assign wr_addr = bram_init_address[ADDR_WIDTH-1:0];

    // Bytes beyond the cache window are dropped rather than aliased, so the
    // upper download address bits must all be zero for a write to land.
    generate
        if (INIT_ADDR_WIDTH > ADDR_WIDTH) begin : g_upper
            assign upper_zero = ~|bram_init_address[INIT_ADDR_WIDTH-1:ADDR_WIDTH];
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    assign wr_en = ~reset & bram_download & bram_wr & upper_zero;

    // Write port: one byte per qualified cycle, contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bram_din;
        end
    end

    // Read port: registered, enabled by cs; sampling mem here with a
    // non-blocking update on the write side gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_reg <= '0;
        end else if (cs) begin
            dout_reg <= mem[addr];
        end
    end

    assign dout = dout_reg;

endmodule

// File: tb/tb_tape_cache_bram.sv
// Directed bench for tape_cache_bram: every cycle pushes the expected dout
// onto a scoreboard queue, which is popped and checked after the edge.
module tb_tape_cache_bram;

    logic        clk = 1'b0;
    logic        reset;
    logic        bram_download;
    logic        bram_wr;
    logic [24:0] bram_init_address;
    logic [7:0]  bram_din;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        cs;

    int total = 0;
    int bad   = 0;

    logic [7:0] model [int];
    logic [7:0] exp_q [$];
    string      tag_q [$];
    logic [7:0] hold_val = 8'h00;

    always #5 clk = ~clk;

    tape_cache_bram #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .INIT_ADDR_WIDTH(25)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bram_download(bram_download),
        .bram_wr(bram_wr),
        .bram_init_address(bram_init_address),
        .bram_din(bram_din),
        .addr(addr),
        .dout(dout),
        .cs(cs)
    );

    // One clock cycle: drive inputs, predict dout, apply model write,
    // advance past the edge and check the prediction.
    task automatic cyc(input string tag, input logic rst, input logic dl,
                       input logic wr, input logic [24:0] wa, input logic [7:0] wd,
                       input logic c, input logic [15:0] ra);
        logic [7:0] e;
        logic [7:0] got_e;
        string      got_t;
        reset             = rst;
        bram_download     = dl;
        bram_wr           = wr;
        bram_init_address = wa;
        bram_din          = wd;
        cs                = c;
        addr              = ra;
        if (rst)
            e = 8'h00;
        else if (c)
            e = model.exists(int'(ra)) ? model[int'(ra)] : 8'hxx;
        else
            e = hold_val;
        hold_val = e;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (!rst && dl && wr && wa[24:16] == 9'd0)
            model[int'(wa[15:0])] = wd;
        @(posedge clk);
        #1;
        got_e = exp_q.pop_front();
        got_t = tag_q.pop_front();
        total++;
        assert (dout === got_e) else begin
            bad++;
            $error("FAIL %s: dout=%h expected=%h", got_t, dout, got_e);
        end
        $display("cycle %-12s rst=%b dl=%b wr=%b wa=%h wd=%h cs=%b ra=%h dout=%h exp=%h",
                 got_t, rst, dl, wr, wa, wd, c, ra, dout, got_e);
    endtask

    task automatic wr_byte(input string tag, input logic [24:0] wa, input logic [7:0] wd);
        cyc(tag, 1'b0, 1'b1, 1'b1, wa, wd, 1'b0, 16'h0000);
    endtask

    task automatic rd(input string tag, input logic [15:0] ra);
        cyc(tag, 1'b0, 1'b0, 1'b0, 25'h0, 8'h00, 1'b1, ra);
    endtask

    logic [7:0] image [8];

    initial begin
        image = '{8'h16, 8'h16, 8'h16, 8'h16, 8'h24, 8'hFF, 8'hFF, 8'h00};

        // Reset with cs high, then idle with cs low
        cyc("reset0", 1'b1, 1'b0, 1'b0, 25'h0, 8'h00, 1'b1, 16'h0000);
        cyc("reset1", 1'b1, 1'b0, 1'b0, 25'h0, 8'h00, 1'b1, 16'h0000);
        cyc("idle",   1'b0, 1'b0, 1'b0, 25'h0, 8'h00, 1'b0, 16'h0000);

        // Download the header bytes and read back
        for (int i = 0; i < 8; i++)
            wr_byte("dl_img", 25'(i), image[i]);
        rd("rd_a4", 16'h0004);
        rd("rd_a7", 16'h0007);
        // Sustained back-to-back reads
        for (int i = 0; i < 8; i++)
            rd("rd_seq", 16'(i));

        // Write qualification
        wr_byte("seed_10", 25'h10, 8'h55);
        cyc("wr_no_dl", 1'b0, 1'b0, 1'b1, 25'h10, 8'hAA, 1'b0, 16'h0000);
        rd("rd_10_a", 16'h0010);
        wr_byte("wr_upper", 25'h10010, 8'hAA);
        rd("rd_10_b", 16'h0010);
        wr_byte("wr_top", 25'h0FFFF, 8'h5A);
        wr_byte("wr_hi_bit", 25'h1000000 | 25'h0FFFF, 8'hC3);
        rd("rd_ffff", 16'hFFFF);

        // Read-first collision
        wr_byte("seed_20", 25'h20, 8'h11);
        cyc("collide", 1'b0, 1'b1, 1'b1, 25'h20, 8'h22, 1'b1, 16'h0020);
        rd("rd_20_new", 16'h0020);

        // cs hold
        rd("rd_a0", 16'h0000);
        for (int i = 0; i < 3; i++)
            cyc("cs_hold", 1'b0, 1'b0, 1'b0, 25'h0, 8'h00, 1'b0, 16'h0004);
        rd("rd_a4_cs", 16'h0004);

        // Reset in the middle of a download
        wr_byte("seed_102", 25'h102, 8'hEE);
        rd("rd_102_pre", 16'h0102);
        wr_byte("dl_100", 25'h100, 8'h01);
        wr_byte("dl_101", 25'h101, 8'h02);
        cyc("rst_dl_102", 1'b1, 1'b1, 1'b1, 25'h102, 8'h03, 1'b1, 16'h0100);
        wr_byte("dl_103", 25'h103, 8'h04);
        wr_byte("dl_104", 25'h104, 8'h05);
        for (int i = 0; i < 5; i++)
            rd("rd_1xx", 16'h0100 + 16'(i));
        // Earlier image survives reset
        rd("rd_a5_post", 16'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tape_cache_bram.md
# tape_cache_bram

Single-port-read / single-port-write byte RAM that caches a downloaded tape image (Oric .TAP) for the cassette loader. The host download interface writes the image byte-by-byte at linear addresses. The tape parser reads it back through a registered, chip-selected read port. The block sits between the ioctl download path and the tape header/program state machine.

## Interface
Parameters:
- ADDR_WIDTH, 16: read address width; depth is 2^ADDR_WIDTH bytes (64 KiB).
- DATA_WIDTH, 8: byte width of the stored words.
- INIT_ADDR_WIDTH, 25: width of the download address bus.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- bram_download  in  1  high while a download is in progress; qualifies writes.
- bram_wr  in  1  write strobe, one byte per asserted cycle.
- bram_init_address  in  INIT_ADDR_WIDTH  download byte address.
- bram_din  in  DATA_WIDTH  download byte.
- addr  in  ADDR_WIDTH  read address.
- dout  out  DATA_WIDTH  registered read data.
- cs  in  1  read enable / chip select.

## Operation
- Storage is an array of 2^ADDR_WIDTH entries of DATA_WIDTH bits. It must infer block RAM: no reset of contents and no initial values. Contents are undefined until written.
- Write: on a rising edge with reset=0, bram_download=1, bram_wr=1 and bram_init_address[INIT_ADDR_WIDTH-1:ADDR_WIDTH]==0, store bram_din at mem[bram_init_address[ADDR_WIDTH-1:0]].
- Dropped writes:
  - Writes with any upper address bit set are dropped. There is no wrap/alias.
  - bram_wr with bram_download=0 is ignored.
  - Writes are ignored while reset=1.
- Read: on a rising edge with reset=0 and cs=1, dout <= mem[addr]. With cs=0, dout holds its previous value.
- Read and write are independent. Both may occur in the same cycle.
- Read-during-write to the same address returns the OLD data (read-first). The new value is visible from the next read cycle on.
- Reset: dout <= 0. Memory contents are preserved across reset.
- There is no full/empty flag and no byte counter. The consumer tracks the image size from the download address.

## Timing
- Write latency: data is committed at the edge where the write is qualified. A read issued at the following edge returns it.
- Read latency: 1 cycle. With addr=A and cs=1 at edge N, mem[A] appears on dout after edge N and is stable until the next enabled read.
- Throughput: one write and one read per cycle, sustained.
- Reset asserted at edge N: dout=0 after edge N, irrespective of cs. The first enabled read after reset deasserts updates dout.
- Reset mid-download: writes in reset cycles are lost. Writes resume on the first cycle with reset=0. Earlier stored bytes are unaffected.
- Address changes while cs=0 have no effect on dout.
- A single clock domain is used. Consumers running on a derived/slower clock must sample dout with cs held and addr stable for at least one clk edge.

## Test plan
- Reset then idle: assert reset 2 cycles with cs=1 -> dout=0x00; deassert with cs=0 -> dout stays 0x00.
- Download and read back: write 16 16 16 16 24 FF FF 00 at addresses 0..7 with bram_download=1. Then read addr 4 with cs=1 -> dout=0x24 one cycle later. Then read addr 7 -> 0x00.
- Write qualification:
  - bram_wr=1 with bram_download=0, data 0xAA at addr 0x10 -> subsequent read of 0x10 returns the prior value (seed 0x55 first).
  - Address 0x10010 with download=1 -> addr 0x0010 still reads 0x55.
- Read-first collision: mem[0x20]=0x11. In one cycle write 0x22 to 0x20 and read 0x20 -> dout=0x11. Next read -> 0x22.
- cs hold: read addr 0 -> 0x16, then cs=0 and addr=4 for 3 cycles -> dout stays 0x16. Then cs=1 -> 0x24.
- Reset mid-download: write 0x01..0x05 at 0x100..0x104 with reset high during the 0x102 write -> 0x100/0x101/0x103/0x104 read back correctly, 0x102 retains its previous value, and dout=0 immediately after reset.
